// File: rtl/ens_pkg.sv
// Shared constants, width helpers and FSM state type for the ensemble vote / argmax block.
package ens_pkg;

    localparam int ENS_NUM_CLASSES = 10;
    localparam int ENS_SCORE_W     = 2;
    localparam int ENS_NUM_ENS     = 4;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int score_w, input int num_ens);
        return score_w + $clog2(num_ens);
    endfunction

    localparam int ENS_ACC_W = acc_width(ENS_SCORE_W, ENS_NUM_ENS);
    localparam int ENS_IDX_W = clog2_min1(ENS_NUM_CLASSES);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_HOLD  = 2'd2
    } ens_state_e;

endpackage

// File: rtl/ens_vote_argmax_if.sv
// Score-word input stream and classification result stream of ens_vote_argmax.
interface ens_vote_argmax_if #(
    parameter int NUM_CLASSES = ens_pkg::ENS_NUM_CLASSES,
    parameter int SCORE_W     = ens_pkg::ENS_SCORE_W,
    parameter int NUM_ENS     = ens_pkg::ENS_NUM_ENS
);
    localparam int ACC_W = ens_pkg::acc_width(SCORE_W, NUM_ENS);
    localparam int IDX_W = ens_pkg::clog2_min1(NUM_CLASSES);

    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_CLASSES*SCORE_W-1:0] in_scores;
    logic                           out_valid;
    logic                           out_ready;
    logic [IDX_W-1:0]               out_class;
    logic [ACC_W-1:0]               out_score;

    modport master (
        output in_valid, in_scores, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  in_valid, in_scores, out_ready,
        output in_ready, out_valid, out_class, out_score
    );
endinterface

// File: rtl/ens_score_acc.sv
// Single-class score accumulator with synchronous clear and add enable.
module ens_score_acc #(
    parameter int SCORE_W = 2,
    parameter int ACC_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               add_en,
    input  logic [SCORE_W-1:0] add_val,
    output logic [ACC_W-1:0]   acc
);
    logic [ACC_W-1:0] acc_r;

    // Running sum; clear wins over add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (add_en) begin
            acc_r <= acc_r + ACC_W'(add_val);
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;
endmodule

// File: rtl/ens_vote_argmax.sv
// Sums NUM_ENS final-layer score words per class, then scans the sums one class
// per cycle and presents the lowest-index maximum as the classification result.
module ens_vote_argmax
    import ens_pkg::*;
#(
    parameter int NUM_CLASSES = ENS_NUM_CLASSES,
    parameter int SCORE_W     = ENS_SCORE_W,
    parameter int NUM_ENS     = ENS_NUM_ENS
) (
    input logic               clk,
    input logic               rst_n,
    ens_vote_argmax_if.slave  bus
);
    localparam int ACC_W = acc_width(SCORE_W, NUM_ENS);
    localparam int IDX_W = clog2_min1(NUM_CLASSES);
    localparam int CNT_W = clog2_min1(NUM_ENS);

    ens_state_e       state_r;
    ens_state_e       state_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [IDX_W-1:0] scan_idx_r;
    logic [IDX_W-1:0] best_idx_r;
    logic [ACC_W-1:0] best_score_r;
    logic [ACC_W-1:0] cur_score_s;
    logic [ACC_W-1:0] acc_s [NUM_CLASSES];
    logic             in_ready_r;
    logic             out_valid_r;
    logic [IDX_W-1:0] out_class_r;
    logic [ACC_W-1:0] out_score_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             beat_last_s;
    logic             scan_last_s;
    logic             cur_better_s;

    // in_ready/out_valid are registered state decodes, so handshakes never feed outputs combinationally.
    assign in_fire_s    = bus.in_valid & in_ready_r;
    assign out_fire_s   = out_valid_r & bus.out_ready;
    assign beat_last_s  = (beat_cnt_r == CNT_W'(NUM_ENS - 1));
    assign scan_last_s  = (scan_idx_r == IDX_W'(NUM_CLASSES - 1));
    assign cur_better_s = (scan_idx_r == {IDX_W{1'b0}}) || (cur_score_s > best_score_r);

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CLASSES; gc++) begin : g_acc
            ens_score_acc #(
                .SCORE_W (SCORE_W),
                .ACC_W   (ACC_W)
            ) u_acc (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (out_fire_s),
                .add_en  (in_fire_s),
                .add_val (bus.in_scores[gc*SCORE_W +: SCORE_W]),
                .acc     (acc_s[gc])
            );
        end
    endgenerate

    // Select the accumulator currently under comparison.
    always_comb begin
        cur_score_s = {ACC_W{1'b0}};
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (scan_idx_r == IDX_W'(c)) begin
                cur_score_s = acc_s[c];
            end else begin
                cur_score_s = cur_score_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (in_fire_s && beat_last_s) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_SCAN: begin
                if (scan_last_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_HOLD: begin
                if (out_fire_s) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_ACCUM;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_ACCUM);
            out_valid_r <= (state_nxt_s == ST_HOLD);
        end
    end

    // Beat counter; wraps to zero on the final ensemble member.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (in_fire_s) begin
            beat_cnt_r <= beat_last_s ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Argmax scan; class 0 seeds the best registers, strict > keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx_r   <= {IDX_W{1'b0}};
            best_idx_r   <= {IDX_W{1'b0}};
            best_score_r <= {ACC_W{1'b0}};
            out_class_r  <= {IDX_W{1'b0}};
            out_score_r  <= {ACC_W{1'b0}};
        end else if (state_r == ST_SCAN) begin
            scan_idx_r <= scan_last_s ? {IDX_W{1'b0}} : scan_idx_r + IDX_W'(1);
            if (cur_better_s) begin
                best_idx_r   <= scan_idx_r;
                best_score_r <= cur_score_s;
            end else begin
                best_idx_r   <= best_idx_r;
                best_score_r <= best_score_r;
            end
            if (scan_last_s) begin
                out_class_r <= cur_better_s ? scan_idx_r : best_idx_r;
                out_score_r <= cur_better_s ? cur_score_s : best_score_r;
            end else begin
                out_class_r <= out_class_r;
                out_score_r <= out_score_r;
            end
        end else begin
            scan_idx_r   <= {IDX_W{1'b0}};
            best_idx_r   <= best_idx_r;
            best_score_r <= best_score_r;
            out_class_r  <= out_class_r;
            out_score_r  <= out_score_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_class = out_class_r;
    assign bus.out_score = out_score_r;
endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed vector table plus stall, reset and randomized back-pressure sequences for ens_vote_argmax.
module tb_ens_vote_argmax;
    import ens_pkg::*;

    localparam int NC = 10;
    localparam int SW = 2;
    localparam int NE = 4;
    localparam int WW = NC * SW;

    typedef logic [WW-1:0] word_t;

    typedef struct {
        string              name;
        logic [NE-1:0][WW-1:0] beats;
        int                 exp_class;
        int                 exp_score;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ens_vote_argmax_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_ENS(NE)) bus ();

    ens_vote_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .NUM_ENS(NE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic word_t set_cls(input word_t w, input int c, input int v);
        word_t r;
        r = w;
        r[c*SW +: SW] = SW'(v);
        return r;
    endfunction

    function automatic word_t all_cls(input int v);
        word_t r;
        r = '0;
        for (int c = 0; c < NC; c++) r[c*SW +: SW] = SW'(v);
        return r;
    endfunction

    function automatic void model(input logic [NE-1:0][WW-1:0] b, output int cls, output int sc);
        int sum;
        cls = 0;
        sc  = -1;
        for (int c = 0; c < NC; c++) begin
            sum = 0;
            for (int k = 0; k < NE; k++) sum += int'(b[k][c*SW +: SW]);
            if (sum > sc) begin
                sc  = sum;
                cls = c;
            end
        end
    endfunction

    // Offer one beat after `idle` quiet cycles; returns on the negedge after acceptance.
    task automatic send_beat(input word_t w, input int idle);
        int g;
        bus.in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_scores = w;
        g = 0;
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("send_beat_timeout", g, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        for (int b = 0; b < NE; b++) send_beat(v.beats[b], 0);
        check({v.name, "_in_ready_scan"}, int'(bus.in_ready), 0);
        wait_result(lat);
        check({v.name, "_latency"}, lat, NC);
        check({v.name, "_class"}, int'(bus.out_class), v.exp_class);
        check({v.name, "_score"}, int'(bus.out_score), v.exp_score);
        handshake();
        check({v.name, "_out_valid_drop"}, int'(bus.out_valid), 0);
        check({v.name, "_in_ready_back"}, int'(bus.in_ready), 1);
    endtask

    vec_t vecs[7];

    initial begin
        int   lat;
        int   bad;
        int   mcls;
        int   msc;
        vec_t v;
        logic [NE-1:0][WW-1:0] rb;

        n_checks = 0;
        n_fail   = 0;

        for (int b = 0; b < NE; b++) begin
            vecs[0].beats[b] = set_cls(all_cls(0), 3, 3);
            vecs[1].beats[b] = all_cls(1);
            vecs[2].beats[b] = set_cls(set_cls(all_cls(0), 9, 3), 2, 2);
            vecs[4].beats[b] = all_cls(0);
            vecs[5].beats[b] = set_cls(all_cls(3), 0, 2);
            vecs[6].beats[b] = set_cls(all_cls(0), 9, 1);
        end
        vecs[0].name = "cls3_max";   vecs[0].exp_class = 3; vecs[0].exp_score = 12;
        vecs[1].name = "all_tie";    vecs[1].exp_class = 0; vecs[1].exp_score = 4;
        vecs[2].name = "last_idx";   vecs[2].exp_class = 9; vecs[2].exp_score = 12;
        vecs[3].beats[0] = set_cls(all_cls(0), 1, 3);
        vecs[3].beats[1] = set_cls(all_cls(0), 7, 3);
        vecs[3].beats[2] = set_cls(all_cls(0), 7, 1);
        vecs[3].beats[3] = set_cls(all_cls(0), 1, 1);
        vecs[3].name = "mixed_tie";  vecs[3].exp_class = 1; vecs[3].exp_score = 4;
        vecs[4].name = "all_zero";   vecs[4].exp_class = 0; vecs[4].exp_score = 0;
        vecs[5].name = "cls0_low";   vecs[5].exp_class = 1; vecs[5].exp_score = 12;
        vecs[6].name = "cls9_only";  vecs[6].exp_class = 9; vecs[6].exp_score = 4;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_scores = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_class", int'(bus.out_class), 0);
        check("rst_out_score", int'(bus.out_score), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Result held under back-pressure while in_valid pulses are ignored.
        for (int b = 0; b < NE; b++) send_beat(set_cls(all_cls(0), 4, 2), 0);
        wait_result(lat);
        check("stall_latency", lat, NC);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid  = k[0];
            bus.in_scores = all_cls(3);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || int'(bus.out_class) != 4 ||
                int'(bus.out_score) != 8 || bus.in_ready !== 1'b0) bad++;
        end
        check("stall_hold_stable", bad, 0);
        handshake();
        check("stall_in_ready_back", int'(bus.in_ready), 1);
        check("stall_out_valid_drop", int'(bus.out_valid), 0);
        v.name = "stall_restart";
        for (int b = 0; b < NE; b++) v.beats[b] = set_cls(all_cls(0), 6, 1);
        v.exp_class = 6;
        v.exp_score = 4;
        run_vec(v);

        // Reset mid-ACCUM and mid-SCAN discards everything.
        for (int b = 0; b < 2; b++) send_beat(set_cls(all_cls(0), 8, 3), 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_accum_in_ready", int'(bus.in_ready), 1);
        check("rst_accum_out_valid", int'(bus.out_valid), 0);
        for (int b = 0; b < NE; b++) send_beat(set_cls(all_cls(0), 8, 3), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        check("rst_scan_no_valid", bad, 0);
        check("rst_scan_in_ready", int'(bus.in_ready), 1);
        v.name = "post_reset";
        for (int b = 0; b < NE; b++) v.beats[b] = set_cls(all_cls(0), 5, 1);
        v.exp_class = 5;
        v.exp_score = 4;
        run_vec(v);

        // Randomized gaps, junk in_valid while busy, and delayed out_ready against the model.
        for (int n = 0; n < 1000; n++) begin
            for (int b = 0; b < NE; b++) rb[b] = WW'({$urandom, $urandom});
            model(rb, mcls, msc);
            for (int b = 0; b < NE; b++) send_beat(rb[b], int'($urandom_range(0, 2)));
            bus.in_valid  = 1'b1;
            bus.in_scores = all_cls(3);
            wait_result(lat);
            bad = (lat != NC) ? 1 : 0;
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || int'(bus.out_class) != mcls) bad++;
            end
            check("rand_class", (bad == 0) ? int'(bus.out_class) : -1, mcls);
            check("rand_score", int'(bus.out_score), msc);
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ens_vote_argmax.md
ENS_VOTE_ARGMAX -- requirements
Module: ens_vote_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores per final-layer output word.
REQ-002 Parameter SCORE_W, default 2, bits per class score from the final neuron layer.
REQ-003 Parameter NUM_ENS, default 4, ensemble members summed per classification.
REQ-004 Derived constant ACC_W = SCORE_W + clog2(NUM_ENS); IDX_W = clog2(NUM_CLASSES).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  final-layer word from one ensemble member present.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_scores  input  NUM_CLASSES*SCORE_W  unsigned class scores; class c at bits [c*SCORE_W +: SCORE_W].
REQ-010 out_valid  output  1  classification result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_class  output  IDX_W  winning class index.
REQ-013 out_score  output  ACC_W  winning summed score.

Function
REQ-014 The block SHALL implement FSM states ACCUM, SCAN, HOLD.
REQ-015 A beat SHALL transfer only on an edge where in_valid and in_ready are both 1.
REQ-016 In ACCUM, in_ready SHALL be 1; in SCAN and HOLD, in_ready SHALL be 0.
REQ-017 Each accepted beat SHALL add every class score into its own ACC_W-bit accumulator; no overflow is possible by sizing.
REQ-018 A beat counter SHALL count 0..NUM_ENS-1; acceptance of beat NUM_ENS-1 SHALL transition ACCUM->SCAN and clear the counter.
REQ-019 SCAN SHALL compare one class per cycle, index 0 to NUM_CLASSES-1, holding running best index/score registers.
REQ-020 Class 0 SHALL seed the best registers; a later class SHALL replace best only if strictly greater (ties resolve to lowest index).
REQ-021 The edge that compares class NUM_CLASSES-1 SHALL load out_class/out_score and enter HOLD; out_valid therefore rises NUM_CLASSES edges after the edge accepting the final beat.
REQ-022 In HOLD, out_valid SHALL be 1 and out_class/out_score SHALL be stable until out_valid and out_ready are both 1.
REQ-023 On the output handshake edge, all accumulators SHALL clear and the FSM SHALL return to ACCUM; in_ready is 1 the following cycle.
REQ-024 out_ready SHALL be ignored outside HOLD; in_valid SHALL be ignored outside ACCUM (in_scores not sampled).
REQ-025 No combinational path SHALL exist from in_valid or out_ready to any output.
REQ-026 Throughput: one classification per NUM_ENS + NUM_CLASSES + 1 cycles minimum with out_ready held high.

Reset
REQ-027 With rst_n = 0 at a rising edge, the FSM SHALL enter ACCUM, beat counter, accumulators, best registers, out_class, out_score SHALL be 0.
REQ-028 Immediately after reset out_valid = 0 and in_ready = 1.
REQ-029 Reset asserted mid-ACCUM, mid-SCAN or in HOLD SHALL discard all partial sums and any pending result with no output handshake.

Structure
REQ-030 NUM_CLASSES, SCORE_W, NUM_ENS defaults, ACC_W/IDX_W derivation and the FSM state enum SHALL reside in a shared package ens_pkg.
REQ-031 One sub-module ens_score_acc (single-class ACC_W accumulator with clear and add-enable) SHALL be instantiated NUM_CLASSES times via generate.

Verification
REQ-032 Reset then 4 beats with class 3 = 2'b11, all others 0 -> out_valid at edge 10 after last beat, out_class = 3, out_score = 12.
REQ-033 4 beats all classes = 2'b01 (all sums 4) -> out_class = 0, out_score = 4 (tie to lowest index).
REQ-034 Class 9 = 3 and class 2 = 2 in every beat -> out_class = 9, out_score = 12; confirms last scanned index is loaded.
REQ-035 Result ready with out_ready = 0 for 20 cycles -> out_valid and outputs stable, in_ready = 0, in_valid pulses ignored; then out_ready = 1 -> in_ready = 1 next cycle, sums restart from 0.
REQ-036 rst_n = 0 after 2 accepted beats and again during SCAN -> no out_valid; next 4 clean beats with class 5 = 1 give out_class = 5, out_score = 4.
REQ-037 Random in_valid/out_ready back-pressure over 1000 classifications -> results match reference model, beat count never exceeds NUM_ENS per result.
